// File: rtl/mips_mc_control_if.sv
// Control-path bundle between the MIPS multicycle controller and its datapath.
// master drives the instruction fields and memory handshake; slave is the controller.
interface mips_mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic [3:0] state_o;
  logic       illegal_op;
  logic       timeout;

  modport master (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, state_o, illegal_op, timeout
  );

  modport slave (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, state_o, illegal_op, timeout
  );
endinterface

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM (Moore). Memory states time out after
// TIMEOUT_CYCLES wait cycles; ERROR is sticky until reset.
// Optional macro JR_SUPPORT_EN adds the JR state (R-type funct 001000).
module mips_mc_control #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic           clk,
  input logic           reset,
  mips_mc_control_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11,
    S_JR     = 4'd12,
    S_ERROR  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
`ifdef JR_SUPPORT_EN
  localparam logic [5:0] FN_JR    = 6'b001000;
`endif

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] wait_cnt;
  logic          wait_last;
  logic          illegal_q;
  logic          timeout_q;
  logic          imm_slt;
  logic          set_illegal;
  logic          set_timeout;

  // The current cycle is the last permitted wait cycle in a memory state.
  assign wait_last = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // State, wait counter, sticky error flags and the IMMEX opcode flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      imm_slt   <= 1'b0;
    end else begin
      state <= state_next;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
      if (state == S_DECODE) imm_slt <= (bus.opcode == OP_SLTI);
      // Leaving a state clears the counter, so every entry into a memory
      // state starts from zero; only waiting cycles advance it.
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if ((state == S_FETCH || state == S_MEMRD || state == S_MEMWR) &&
                   !bus.mem_ready) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  // Next-state selection and error-flag set requests.
  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_next = S_DECODE;
        end else if (wait_last) begin
          state_next  = S_ERROR;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        unique case (bus.opcode)
          OP_RTYPE: begin
`ifdef JR_SUPPORT_EN
            if (bus.funct == FN_JR) state_next = S_JR;
            else                    state_next = S_RTEX;
`else
            state_next = S_RTEX;
`endif
          end
          OP_LW, OP_SW:     state_next = S_MEMADR;
          OP_BEQ:           state_next = S_BRANCH;
          OP_J:             state_next = S_JUMP;
          OP_ADDI, OP_SLTI: state_next = S_IMMEX;
          default: begin
            state_next  = S_ERROR;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (bus.mem_ready) begin
          state_next = S_MEMWB;
        end else if (wait_last) begin
          state_next  = S_ERROR;
          set_timeout = 1'b1;
        end
      end
      S_MEMWB: state_next = S_FETCH;
      S_MEMWR: begin
        if (bus.mem_ready) begin
          state_next = S_FETCH;
        end else if (wait_last) begin
          state_next  = S_ERROR;
          set_timeout = 1'b1;
        end
      end
      S_RTEX:   state_next = S_RTWB;
      S_RTWB:   state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_IMMEX:  state_next = S_IMMWB;
      S_IMMWB:  state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
`ifdef JR_SUPPORT_EN
      S_JR:     state_next = S_FETCH;
`endif
      S_ERROR:  state_next = S_ERROR;
      default:  state_next = S_ERROR;
    endcase
  end

  // Output decode from the registered state; FETCH also gates its IR/PC
  // write strobes with the memory handshake.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_src        = 2'b00;
    unique case (state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 2'b11;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        bus.alu_op    = 2'b11;
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 2'b11;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      S_RTEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b00;
      end
      S_RTWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = 2'b01;
      end
      S_IMMEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = imm_slt ? 2'b10 : 2'b11;
      end
      S_IMMWB: begin
        bus.reg_write = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'b10;
      end
`ifdef JR_SUPPORT_EN
      S_JR: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'b11;
      end
`endif
      default: ;
    endcase
  end

  assign bus.state_o    = state;
  assign bus.illegal_op = illegal_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control; expected values are hand-derived.
module tb_mips_mc_control;

  logic clk;
  logic reset;
  int unsigned tests;
  int unsigned failed;

  mips_mc_control_if bus ();

  mips_mc_control #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tests         = 0;
    failed        = 0;
    reset         = 1'b1;
    bus.opcode    = 6'b100011;
    bus.funct     = 6'b000000;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    release_reset();

    // Reset state / first cycle is FETCH decode
    check("rst_state", bus.state_o, 0);
    check("rst_illegal", bus.illegal_op, 0);
    check("rst_timeout", bus.timeout, 0);
    check("fetch_mem_read", bus.mem_read, 1);
    check("fetch_alu_src_b", bus.alu_src_b, 2'b01);
    check("fetch_alu_op", bus.alu_op, 2'b11);
    check("fetch_ir_write_rdy", bus.ir_write, 1);
    check("fetch_pc_write_rdy", bus.pc_write, 1);
    bus.mem_ready = 1'b0;
    #1;
    check("fetch_ir_write_wait", bus.ir_write, 0);
    check("fetch_pc_write_wait", bus.pc_write, 0);
    check("fetch_hold_state", bus.state_o, 0);
    bus.mem_ready = 1'b1;

    // lw with mem_ready high: 0,1,2,3,4,0
    step(); check("lw_decode", bus.state_o, 1);
    check("decode_alu_src_b", bus.alu_src_b, 2'b11);
    step(); check("lw_memadr", bus.state_o, 2);
    check("memadr_src_a", bus.alu_src_a, 1);
    check("memadr_src_b", bus.alu_src_b, 2'b10);
    step(); check("lw_memrd", bus.state_o, 3);
    check("memrd_iord", bus.i_or_d, 1);
    check("memrd_mem_read", bus.mem_read, 1);
    step(); check("lw_memwb", bus.state_o, 4);
    check("memwb_reg_write", bus.reg_write, 1);
    check("memwb_mem_to_reg", bus.mem_to_reg, 1);
    check("memwb_reg_dst", bus.reg_dst, 0);
    step(); check("lw_fetch", bus.state_o, 0);

    // sw with 3 wait cycles in MEMWR
    bus.opcode = 6'b101011;
    step(); check("sw_decode", bus.state_o, 1);
    step(); check("sw_memadr", bus.state_o, 2);
    step(); check("sw_memwr", bus.state_o, 5);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sw_wait_state", bus.state_o, 5);
      check("sw_wait_mem_write", bus.mem_write, 1);
      step();
    end
    bus.mem_ready = 1'b1;
    #1;
    check("sw_last_state", bus.state_o, 5);
    check("sw_last_mem_write", bus.mem_write, 1);
    step(); check("sw_fetch", bus.state_o, 0);
    check("sw_timeout", bus.timeout, 0);

    // lw: handshake on the 16th wait cycle of MEMRD wins over timeout
    bus.opcode = 6'b100011;
    step(); step(); step();
    check("lw2_memrd", bus.state_o, 3);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("lw2_still_memrd", bus.state_o, 3);
    bus.mem_ready = 1'b1;
    step(); check("lw2_memwb", bus.state_o, 4);
    check("lw2_no_timeout", bus.timeout, 0);
    step(); check("lw2_fetch", bus.state_o, 0);

    // slti: IMMEX alu_op=10 held even if opcode changes afterwards
    bus.opcode = 6'b001010;
    step(); check("slti_decode", bus.state_o, 1);
    step(); check("slti_immex", bus.state_o, 9);
    bus.opcode = 6'b001000;
    #1;
    check("slti_alu_op", bus.alu_op, 2'b10);
    check("slti_src_b", bus.alu_src_b, 2'b10);
    check("slti_src_a", bus.alu_src_a, 1);
    step(); check("slti_immwb", bus.state_o, 10);
    check("slti_reg_write", bus.reg_write, 1);
    check("slti_reg_dst", bus.reg_dst, 0);
    step(); check("slti_fetch", bus.state_o, 0);

    // addi: alu_op=11
    bus.opcode = 6'b001000;
    step(); step(); check("addi_immex", bus.state_o, 9);
    bus.opcode = 6'b001010;
    #1;
    check("addi_alu_op", bus.alu_op, 2'b11);
    step(); check("addi_immwb", bus.state_o, 10);
    step(); check("addi_fetch", bus.state_o, 0);

    // beq
    bus.opcode = 6'b000100;
    step(); step(); check("beq_state", bus.state_o, 8);
    check("beq_pwc", bus.pc_write_cond, 1);
    check("beq_pc_src", bus.pc_src, 2'b01);
    check("beq_alu_op", bus.alu_op, 2'b01);
    step(); check("beq_fetch", bus.state_o, 0);

    // j
    bus.opcode = 6'b000010;
    step(); step(); check("j_state", bus.state_o, 11);
    check("j_pc_write", bus.pc_write, 1);
    check("j_pc_src", bus.pc_src, 2'b10);
    step(); check("j_fetch", bus.state_o, 0);

    // R-type add (funct 100000)
    bus.opcode = 6'b000000;
    bus.funct  = 6'b100000;
    step(); step(); check("add_rtex", bus.state_o, 6);
    check("rtex_alu_op", bus.alu_op, 2'b00);
    check("rtex_src_a", bus.alu_src_a, 1);
    step(); check("add_rtwb", bus.state_o, 7);
    check("rtwb_reg_dst", bus.reg_dst, 1);
    check("rtwb_reg_write", bus.reg_write, 1);
    step(); check("add_fetch", bus.state_o, 0);

    // R-type funct 001000
    bus.funct = 6'b001000;
    step(); step();
`ifdef JR_SUPPORT_EN
    check("jr_state", bus.state_o, 12);
    check("jr_pc_src", bus.pc_src, 2'b11);
    check("jr_pc_write", bus.pc_write, 1);
    step(); check("jr_fetch", bus.state_o, 0);
`else
    check("jr_as_rtex", bus.state_o, 6);
    step(); check("jr_as_rtwb", bus.state_o, 7);
    step(); check("jr_as_fetch", bus.state_o, 0);
`endif

    // Illegal opcode -> ERROR, sticky; reset mid-ERROR clears it
    bus.opcode = 6'b111111;
    step(); check("ill_decode", bus.state_o, 1);
    step(); check("ill_error", bus.state_o, 15);
    check("ill_flag", bus.illegal_op, 1);
    check("ill_no_timeout", bus.timeout, 0);
    step(); step();
    check("ill_sticky", bus.state_o, 15);
    check("ill_flag_held", bus.illegal_op, 1);
    check("ill_mem_read", bus.mem_read, 0);
    check("ill_ir_write", bus.ir_write, 0);
    reset = 1'b1;
    #1;
    check("ill_rst_state", bus.state_o, 0);
    check("ill_rst_flag", bus.illegal_op, 0);
    release_reset();

    // Timeout in FETCH after 16 wait cycles
    bus.opcode    = 6'b100011;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("to_fetch_15", bus.state_o, 0);
    check("to_flag_15", bus.timeout, 0);
    step(); check("to_error", bus.state_o, 15);
    check("to_flag", bus.timeout, 1);
    check("to_illegal", bus.illegal_op, 0);
    bus.mem_ready = 1'b1;
    step(); step(); step();
    check("to_sticky", bus.state_o, 15);
    check("to_flag_held", bus.timeout, 1);
    check("to_pc_write", bus.pc_write, 0);
    reset = 1'b1;
    #1;
    check("to_rst_state", bus.state_o, 0);
    check("to_rst_flag", bus.timeout, 0);
    release_reset();
    step(); check("post_rst_decode", bus.state_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
